ram_arbiter: RTL and testbench

- Shares the single-port program/data RAM between two requesters: port A (CPU bus: microcode MAR/RAM-in/RAM-out path) and port B (program loader / debug monitor).
- Sits between both requesters and the RAM macro and owns all RAM control lines.
- Grants are registered, with round-robin tie-break and a bounded hold so neither side starves.

---
 rtl/ram_arbiter_if.sv | 59 +++++
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bus bundle between the two RAM requesters, the shared
// RAM macro and ram_arbiter.
//
// Port A / port B signals:
//   req_x     level request, held until the requester is done
//   we_x      1 = write, 0 = read
//   addr_x    requested RAM address
//   wdata_x   write data
//   gnt_x     port x owns the RAM this cycle
//   rvalid_x  rdata carries port x's read result this cycle
// Shared:
//   rdata                   read data, qualified by rvalid_a / rvalid_b
//   ram_we/addr/wdata       RAM macro control, owned by the arbiter
//   ram_rdata               RAM synchronous read data (one cycle after address)
//
// Modports:
//   slave   the arbiter
//   master  the system side (both requesters plus the RAM macro)
interface ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              gnt_a;
  logic              rvalid_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_b;
  logic              rvalid_b;

  logic [DATA_W-1:0] rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  ram_rdata,
    output gnt_a, rvalid_a, gnt_b, rvalid_b,
    output rdata, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output ram_rdata,
    input  gnt_a, rvalid_a, gnt_b, rvalid_b,
    input  rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between port A (CPU bus) and
// port B (loader / debug monitor).
//
// Grants are registered. Ties in IDLE go to the port that did not own the
// RAM last. Under continuous contention an owner keeps the RAM for at most
// MAX_HOLD access cycles before ownership is forced to the other port.
//
// Ports:
//   clk   system clock, posedge
//   rst   asynchronous, active-low reset
//   bus   ram_arbiter_if.slave (requester A/B, rdata, RAM macro signals)
module ram_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  // One spare bit so the counter can represent MAX_HOLD-1 without wrapping.
  localparam int                HOLD_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              last_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic              acc_a;
  logic              acc_b;

  assign acc_a = gnt_a & bus.req_a;
  assign acc_b = gnt_b & bus.req_b;

  // Next-owner decision. hold_nxt only advances while the owner keeps
  // accessing and the other port is waiting; any other outcome clears it.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) state_nxt = last_b ? OWN_A : OWN_B;
        else if (bus.req_a)         state_nxt = OWN_A;
        else if (bus.req_b)         state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!bus.req_a) begin
          state_nxt = bus.req_b ? OWN_B : IDLE;
        end else if (bus.req_b) begin
          if (hold_cnt == HOLD_LAST) state_nxt = OWN_B;
          else                       hold_nxt  = hold_cnt + HOLD_W'(1);
        end
      end
      OWN_B: begin
        if (!bus.req_b) begin
          state_nxt = bus.req_a ? OWN_A : IDLE;
        end else if (bus.req_a) begin
          if (hold_cnt == HOLD_LAST) state_nxt = OWN_A;
          else                       hold_nxt  = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership register; rvalid is tagged with the port that issued the read
  // in this cycle, independent of who owns the RAM next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      hold_cnt <= '0;
      last_b   <= 1'b1;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_a    <= (state_nxt == OWN_A);
      gnt_b    <= (state_nxt == OWN_B);
      hold_cnt <= hold_nxt;
      if (state_nxt != state && state_nxt != IDLE)
        last_b <= (state_nxt == OWN_B);
      rvalid_a <= acc_a & ~bus.we_a;
      rvalid_b <= acc_b & ~bus.we_b;
    end
  end

  // RAM control follows the owner combinationally and idles at zero.
  assign bus.ram_we    = (acc_a & bus.we_a) | (acc_b & bus.we_b);
  assign bus.ram_addr  = acc_a ? bus.addr_a  : (acc_b ? bus.addr_b  : '0);
  assign bus.ram_wdata = acc_a ? bus.wdata_a : (acc_b ? bus.wdata_b : '0);

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = rvalid_a;
  assign bus.rvalid_b = rvalid_b;
  assign bus.rdata    = bus.ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a RAM macro model, a
// reference model of the arbitration rules and a per-cycle compare process.
module tb_ram_arbiter;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // RAM macro: synchronous read-before-write.
  logic [DATA_W-1:0] ram [16];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  // Reference model: owner 0 = none, 1 = A, 2 = B. streak counts the
  // owner's consecutive accesses while the other port is waiting.
  int                m_owner  = 0;
  int                m_last   = 2;
  int                m_streak = 0;
  int                m_nxt;
  logic [DATA_W-1:0] m_mem [16];
  logic              m_rva = 1'b0;
  logic              m_rvb = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_mine, m_theirs, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]   = DATA_W'(i * 17);
      m_mem[i] = DATA_W'(i * 17);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner  = 0;
      m_last   = 2;
      m_streak = 0;
      m_rva    = 1'b0;
      m_rvb    = 1'b0;
    end else begin
      m_mine   = (m_owner == 1) ? bus.req_a : (m_owner == 2) ? bus.req_b : 1'b0;
      m_theirs = (m_owner == 1) ? bus.req_b : (m_owner == 2) ? bus.req_a : 1'b0;
      m_we     = (m_owner == 1) ? bus.we_a    : bus.we_b;
      m_addr   = (m_owner == 1) ? bus.addr_a  : bus.addr_b;
      m_wd     = (m_owner == 1) ? bus.wdata_a : bus.wdata_b;
      m_rva    = (m_owner == 1) && m_mine && !m_we;
      m_rvb    = (m_owner == 2) && m_mine && !m_we;
      if (m_rva || m_rvb) m_rdata = m_mem[m_addr];
      if (m_mine && m_we) m_mem[m_addr] = m_wd;
      if (m_owner == 0) begin
        if (bus.req_a && bus.req_b) m_nxt = 3 - m_last;
        else if (bus.req_a)         m_nxt = 1;
        else if (bus.req_b)         m_nxt = 2;
        else                        m_nxt = 0;
      end else if (!m_mine) begin
        m_nxt = m_theirs ? 3 - m_owner : 0;
      end else if (m_theirs) begin
        m_streak++;
        m_nxt = (m_streak >= MAX_HOLD) ? 3 - m_owner : m_owner;
      end else begin
        m_streak = 0;
        m_nxt    = m_owner;
      end
      if (m_nxt != m_owner) begin
        m_streak = 0;
        if (m_nxt != 0) m_last = m_nxt;
      end
      m_owner = m_nxt;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  logic              e_acc_a, e_acc_b, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wd;
  always @(negedge clk) begin
    e_acc_a = (m_owner == 1) && bus.req_a;
    e_acc_b = (m_owner == 2) && bus.req_b;
    e_we    = (e_acc_a && bus.we_a) || (e_acc_b && bus.we_b);
    e_addr  = e_acc_a ? bus.addr_a  : e_acc_b ? bus.addr_b  : '0;
    e_wd    = e_acc_a ? bus.wdata_a : e_acc_b ? bus.wdata_b : '0;
    check("m_gnt_a",     bus.gnt_a,     m_owner == 1);
    check("m_gnt_b",     bus.gnt_b,     m_owner == 2);
    check("m_rvalid_a",  bus.rvalid_a,  m_rva);
    check("m_rvalid_b",  bus.rvalid_b,  m_rvb);
    check("m_ram_we",    bus.ram_we,    e_we);
    check("m_ram_addr",  bus.ram_addr,  e_addr);
    check("m_ram_wdata", bus.ram_wdata, e_wd);
    if (m_rva || m_rvb) check("m_rdata", bus.rdata, m_rdata);
  end

  int n;

  initial begin
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    rst = 1'b0;
    repeat (2) tick;
    check("rst_gnt_a",    bus.gnt_a,    0);
    check("rst_gnt_b",    bus.gnt_b,    0);
    check("rst_ram_we",   bus.ram_we,   0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_rvalid_a", bus.rvalid_a, 0);
    rst = 1'b1;

    // Single-port write from B.
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 4'd3; bus.wdata_b = 8'h5A;
    tick;
    check("wr_gnt_b",     bus.gnt_b,     1);
    check("wr_gnt_a",     bus.gnt_a,     0);
    check("wr_ram_we",    bus.ram_we,    1);
    check("wr_ram_addr",  bus.ram_addr,  3);
    check("wr_ram_wdata", bus.ram_wdata, 8'h5A);
    tick;

    // B drops and A rises together: single-edge handover, then read back.
    bus.req_b = 1'b0; bus.we_b = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'd3;
    tick;
    check("ho_gnt_a",    bus.gnt_a,    1);
    check("ho_gnt_b",    bus.gnt_b,    0);
    check("rd_ram_addr", bus.ram_addr, 3);
    tick;
    check("rd_rvalid_a", bus.rvalid_a, 1);
    check("rd_rvalid_b", bus.rvalid_b, 0);
    check("rd_rdata",    bus.rdata,    8'h5A);
    bus.req_a = 1'b0;
    tick;
    check("rd_rvalid_once", bus.rvalid_a, 0);
    check("rd_idle_gnt_a",  bus.gnt_a,    0);

    // Tie-break from reset, then again with last owner A.
    rst = 1'b0;
    tick; tick;
    rst = 1'b1;
    bus.req_a = 1'b1; bus.addr_a = 4'd0;
    bus.req_b = 1'b1; bus.addr_b = 4'd1;
    tick;
    check("tie1_gnt_a", bus.gnt_a, 1);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick;
    check("tie_idle_gnt_b", bus.gnt_b, 0);
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    tick;
    check("tie2_gnt_b", bus.gnt_b, 1);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick;

    // Starvation bound: A reads addr 5 continuously, B raises a read of 3.
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'd5;
    tick; tick; tick;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 4'd3;
    n = 0;
    for (int i = 0; i < 20 && !bus.gnt_b; i++) begin
      if (bus.gnt_a && bus.req_a) n++;
      tick;
    end
    check("hold_a_cycles", n, 8);
    check("hold_gnt_b",    bus.gnt_b,    1);
    check("tag_rvalid_a",  bus.rvalid_a, 1);
    check("tag_rvalid_b",  bus.rvalid_b, 0);
    check("tag_rdata",     bus.rdata,    8'h55);
    check("tag_b_addr",    bus.ram_addr, 3);
    n = 0;
    for (int i = 0; i < 20 && !bus.gnt_a; i++) begin
      if (bus.gnt_b && bus.req_b) n++;
      tick;
    end
    check("hold_b_cycles", n, 8);
    check("tag2_rvalid_b", bus.rvalid_b, 1);
    check("tag2_rdata",    bus.rdata,    8'h5A);
    n = 0;
    for (int i = 0; i < 20 && !bus.gnt_b; i++) begin
      if (bus.gnt_a && bus.req_a) n++;
      tick;
    end
    check("hold_a2_cycles", n, 8);

    // Reset mid-operation: B owns with a read in flight.
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_gnt_b",  bus.gnt_b,    0);
    check("mid_rst_ram_we", bus.ram_we,   0);
    check("mid_rst_addr",   bus.ram_addr, 0);
    @(posedge clk); #1;
    check("mid_rst_rvalid_b", bus.rvalid_b, 0);
    rst = 1'b1;
    tick;
    check("post_rst_gnt_a", bus.gnt_a, 1);

    // Inputs changing while not granted must not reach the RAM.
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick;
    bus.we_a = 1'b1; bus.addr_a = 4'd7; bus.wdata_a = 8'hC3;
    tick;
    check("ng_ram_we",   bus.ram_we,   0);
    check("ng_ram_addr", bus.ram_addr, 0);
    bus.req_a = 1'b1;
    tick;
    check("aw_ram_we", bus.ram_we, 1);
    tick;
    bus.req_a = 1'b0; bus.we_a = 1'b0;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 4'd7;
    tick;
    check("br_gnt_b", bus.gnt_b, 1);
    tick;
    check("br_rvalid_b", bus.rvalid_b, 1);
    check("br_rdata",    bus.rdata,    8'hC3);
    bus.req_b = 1'b0;
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
